stream_packet_engine: RTL

//  System-side packet processor placed between the Opal Kelly pipe's sys_rx and sys_tx streams.

---
 rtl/stream_packet_engine.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/stream_packet_engine.sv
// rtl/stream_packet_engine.sv - header/payload/checksum packet processor between rx and tx streams
//
// Purpose:
//   Accepts a header word on rx, echoes it to tx, then transforms len payload
//   words according to the header mode and finally appends a checksum trailer
//   (sum of the transformed payload words, mod 2^DATA_WIDTH).
//   Header: mode = rx[DATA_WIDTH-1:DATA_WIDTH-2], len = rx[LEN_WIDTH-1:0].
//   Modes: 0 pass, 1 invert, 2 increment, 3 byte-reverse.
//
// Ports:
//   s_clk, s_rst        clock and synchronous active-high reset
//   rx_valid/rx_ready/rx  input word stream (valid/ready handshake)
//   tx_valid/tx_ready/tx  output word stream, tx and tx_valid registered
//   busy                high while a packet is in progress (payload or trailer)
//   pkt_count           packets whose trailer has been loaded; wraps

`timescale 1ns/1ps

module stream_packet_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] rx,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam int NBYTES = DATA_WIDTH / 8;

  localparam logic [DATA_WIDTH-1:0] DATA_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = 0;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;

  typedef enum logic [1:0] {
    S_HEAD = 2'd0,
    S_DATA = 2'd1,
    S_SUM  = 2'd2
  } state_t;

  state_t                state_q;
  logic [1:0]            mode_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [DATA_WIDTH-1:0] csum_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic                  tx_valid_q;
  logic [CNT_WIDTH-1:0]  pkt_count_q;

  logic                  free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] word_d;
  logic [DATA_WIDTH-1:0] csum_d;
  logic [1:0]            hdr_mode;
  logic [LEN_WIDTH-1:0]  hdr_len;

  function automatic logic [DATA_WIDTH-1:0] xform(input logic [1:0]            m,
                                                  input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = w;
    case (m)
      2'd1: r = ~w;
      2'd2: r = w + DATA_ONE;
      2'd3: begin
        for (int b = 0; b < NBYTES; b++) begin
          r[8*b +: 8] = w[DATA_WIDTH-8-8*b +: 8];
        end
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // The output slot can take a new word when it is empty or is being
  // handed off this very cycle, so full throughput needs no skid buffer.
  assign free     = ~tx_valid_q | tx_ready;
  assign rx_ready = free & (state_q != S_SUM);
  assign accept   = rx_valid & rx_ready;

  assign hdr_mode = rx[DATA_WIDTH-1 -: 2];
  assign hdr_len  = rx[LEN_WIDTH-1:0];
  assign word_d   = xform(mode_q, rx);
  assign csum_d   = csum_q + word_d;

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q     <= S_HEAD;
      mode_q      <= 2'd0;
      remaining_q <= LEN_ZERO;
      csum_q      <= '0;
      tx_q        <= '0;
      tx_valid_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      // Handoff clears valid; any load below overrides it in the same cycle.
      if (tx_ready) begin
        tx_valid_q <= 1'b0;
      end

      case (state_q)
        S_HEAD: begin
          if (accept) begin
            tx_q        <= rx;
            tx_valid_q  <= 1'b1;
            mode_q      <= hdr_mode;
            remaining_q <= hdr_len;
            csum_q      <= '0;
            state_q     <= (hdr_len == LEN_ZERO) ? S_SUM : S_DATA;
          end
        end

        S_DATA: begin
          if (accept) begin
            tx_q        <= word_d;
            tx_valid_q  <= 1'b1;
            csum_q      <= csum_d;
            remaining_q <= remaining_q - LEN_ONE;
            if (remaining_q == LEN_ONE) begin
              state_q <= S_SUM;
            end
          end
        end

        S_SUM: begin
          // rx is stalled here; this is the single bubble per packet.
          if (free) begin
            tx_q        <= csum_q;
            tx_valid_q  <= 1'b1;
            pkt_count_q <= pkt_count_q + CNT_ONE;
            state_q     <= S_HEAD;
          end
        end

        default: state_q <= S_HEAD;
      endcase
    end
  end

  assign tx        = tx_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = (state_q != S_HEAD);
  assign pkt_count = pkt_count_q;

endmodule
